// File: rtl/rv_mc_ctl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core.
// Optional RV_MC_CTL_ILLEGAL_TRAP_EN: unknown opcodes trap to ERR instead of retiring as NOP.
module rv_mc_ctl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5,
    parameter int unsigned RET_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             branch_taken,
    input  logic             stall,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       u_sel,
    output logic [2:0]       bj_type,
    output logic             fault,
    output logic [RET_W-1:0] retired
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_BAD} cls_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nx;
    cls_t             cls, d_cls;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_inc, retire, to_err;
    logic             d_m2r, d_src;
    logic [1:0]       d_op, d_u;
    logic [2:0]       d_bj;
    logic             unused_instr;
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
    logic             trap;
`endif

    assign unused_instr = ^{instr[31:15], instr[11:7]};

    always_comb begin
        d_m2r = 1'b0;
        d_src = 1'b0;
        d_op  = 2'b00;
        d_u   = 2'b00;
        d_bj  = 3'b010;
        d_cls = C_ALU;
        case (instr[6:0])
            7'b0110011: d_cls = C_ALU;
            7'b0010011: begin d_op = 2'b01; d_src = 1'b1; end
            7'b0000011: begin d_m2r = 1'b1; d_src = 1'b1; d_cls = C_LOAD; end
            7'b0100011: begin d_src = 1'b1; d_cls = C_STORE; end
            7'b1100011: begin d_bj = instr[14:12]; d_cls = C_BRANCH; end
            7'b1101111,
            7'b1100111: begin d_bj = 3'b011; d_src = 1'b1; d_cls = C_JUMP; end
            7'b0110111: begin d_op = 2'b10; d_src = 1'b1; d_u = 2'b01; end
            7'b0010111: begin d_op = 2'b10; d_src = 1'b1; d_u = 2'b10; end
            default:    begin d_op = 2'b11; d_cls = C_BAD; end
        endcase
    end

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        reg_write = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        retire    = 1'b0;
        to_err    = 1'b0;
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
        trap      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                // State idles in FETCH under reset; keep the request low there.
                imem_req = rst_n;
                if (imem_ack) begin
                    ir_we    = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = S_DECODE;
                end else if (cnt == CNT_MAX) begin
                    to_err   = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    cnt_inc  = 1'b1;
                end
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_LOAD, C_STORE: state_nx = S_MEM;
                    C_BRANCH: begin
                        pc_sel   = branch_taken;
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    C_JUMP: begin
                        pc_sel   = 1'b1;
                        state_nx = S_WB;
                    end
                    C_BAD: begin
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
                        trap     = 1'b1;
                        to_err   = 1'b1;
                        state_nx = S_ERR;
`else
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
`endif
                    end
                    default: state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_STORE);
                if (dmem_ack) begin
                    cnt_clr = 1'b1;
                    if (cls == C_STORE) begin
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (cnt == CNT_MAX) begin
                    to_err   = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    cnt_inc  = 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                pc_sel    = (cls == C_JUMP);
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            default: state_nx = S_ERR;
        endcase
        // Stall overrides everything that would change state; requests stay up,
        // so an ack seen while stalled is simply dropped.
        if (stall) begin
            state_nx  = state;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            reg_write = 1'b0;
            cnt_clr   = 1'b0;
            cnt_inc   = 1'b0;
            retire    = 1'b0;
            to_err    = 1'b0;
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
            trap      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            cls        <= C_ALU;
            cnt        <= '0;
            mem_to_reg <= 1'b0;
            alu_src    <= 1'b0;
            alu_op     <= '0;
            u_sel      <= '0;
            bj_type    <= '0;
            retired    <= '0;
            fault      <= 1'b0;
        end else begin
            state <= state_nx;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CNT_W'(1);
            if (state == S_DECODE && !stall) begin
                cls        <= d_cls;
                mem_to_reg <= d_m2r;
                alu_src    <= d_src;
                alu_op     <= d_op;
                u_sel      <= d_u;
                bj_type    <= d_bj;
            end
            if (retire)
                retired <= retired + RET_W'(1);
            if (to_err)
                fault <= 1'b1;
        end
    end

`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal <= 1'b0;
        else if (trap)
            illegal <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_rv_mc_ctl.sv
// Bench for rv_mc_ctl: directed table, random instruction stream against a
// transaction-level latency model, plus stall, timeout and reset sequences.
module tb_rv_mc_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0, stall = 1'b0;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_write;
    logic        mem_to_reg, alu_src, fault;
    logic [1:0]  alu_op, u_sel;
    logic [2:0]  bj_type;
    logic [31:0] retired;
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    rv_mc_ctl #(.TIMEOUT_CYCLES(16), .CNT_W(5), .RET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .branch_taken(branch_taken), .stall(stall),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .u_sel(u_sel), .bj_type(bj_type),
        .fault(fault), .retired(retired)
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       m2r;
        logic       src;
        logic [1:0] op;
        logic [1:0] u;
        logic [2:0] bj;
    } fields_t;

    typedef struct {
        logic [31:0] w;
        int          di;
        int          dd;
        logic        bt;
        fields_t     f;
    } vec_t;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_BAD} kind_t;

    int unsigned vectors = 0, miscompares = 0;
    logic [31:0] exp_ret = '0;
    vec_t        tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic fields_t mk(input logic m2r, input logic src, input logic [1:0] op,
                                   input logic [1:0] u, input logic [2:0] bj);
        mk = '{m2r, src, op, u, bj};
    endfunction

    function automatic kind_t kind_of(input logic [31:0] w);
        case (w[6:0])
            7'h33, 7'h13, 7'h37, 7'h17: kind_of = K_ALU;
            7'h03: kind_of = K_LOAD;
            7'h23: kind_of = K_STORE;
            7'h63: kind_of = K_BRANCH;
            7'h6f, 7'h67: kind_of = K_JUMP;
            default: kind_of = K_BAD;
        endcase
    endfunction

    // Control-field table for each opcode class.
    function automatic fields_t ref_fields(input logic [31:0] w);
        logic [2:0] f3;
        f3 = w[14:12];
        case (w[6:0])
            7'h33: ref_fields = mk(1'b0, 1'b0, 2'b00, 2'b00, 3'b010);
            7'h13: ref_fields = mk(1'b0, 1'b1, 2'b01, 2'b00, 3'b010);
            7'h03: ref_fields = mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b010);
            7'h23: ref_fields = mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b010);
            7'h63: ref_fields = mk(1'b0, 1'b0, 2'b00, 2'b00, f3);
            7'h6f, 7'h67: ref_fields = mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b011);
            7'h37: ref_fields = mk(1'b0, 1'b1, 2'b10, 2'b01, 3'b010);
            7'h17: ref_fields = mk(1'b0, 1'b1, 2'b10, 2'b10, 3'b010);
            default: ref_fields = mk(1'b0, 1'b0, 2'b11, 2'b00, 3'b010);
        endcase
    endfunction

    function automatic logic [31:0] all_outs();
        all_outs = 32'({imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_write,
                        mem_to_reg, alu_src, alu_op, u_sel, bj_type, fault});
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        #1;
        check({tag, "_rst_outs"}, all_outs(), 32'd0);
        check({tag, "_rst_retired"}, retired, 32'd0);
        exp_ret = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One instruction from its first FETCH cycle; expectations come from the
    // per-class cycle budget: fetch di+1, decode 1, exec 1, mem dd+1, wb 1.
    task automatic run_instr(input logic [31:0] w, input int di, input int dd,
                             input logic bt, input fields_t ef, input string tag);
        kind_t k;
        int    len, mem_end, n_ir, ir_c, n_pc, pc_c, n_rw, rw_c, n_dreq, n_dwe, n_ireq;
        logic  sel_at_pc, is_mem, exp_sel;
        k       = kind_of(w);
        is_mem  = (k == K_LOAD) || (k == K_STORE);
        mem_end = di + 4 + dd;
        case (k)
            K_ALU, K_JUMP:     len = di + 4;
            K_LOAD:            len = di + 5 + dd;
            K_STORE:           len = mem_end;
            default:           len = di + 3;
        endcase
        exp_sel = (k == K_JUMP) || (k == K_BRANCH && bt);
        n_ir = 0; ir_c = 0; n_pc = 0; pc_c = 0; n_rw = 0; rw_c = 0;
        n_dreq = 0; n_dwe = 0; n_ireq = 0; sel_at_pc = 1'b0;
        instr = w;
        branch_taken = bt;
        for (int c = 1; c <= len; c++) begin
            imem_ack = (c == di + 1);
            dmem_ack = is_mem && (c == mem_end);
            @(negedge clk);
            if (ir_we) begin n_ir++; ir_c = c; end
            if (pc_we) begin n_pc++; pc_c = c; sel_at_pc = pc_sel; end
            if (reg_write) begin n_rw++; rw_c = c; end
            if (dmem_req) n_dreq++;
            if (dmem_we) n_dwe++;
            if (imem_req) n_ireq++;
            next_cycle();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        exp_ret  = exp_ret + 32'd1;
        check({tag, "_ir_we_cycle"}, ir_c, di + 1);
        check({tag, "_ir_we_count"}, n_ir, 1);
        check({tag, "_imem_req_cycles"}, n_ireq, di + 1);
        check({tag, "_pc_we_cycle"}, pc_c, len);
        check({tag, "_pc_we_count"}, n_pc, 1);
        check({tag, "_pc_sel"}, 32'(sel_at_pc), 32'(exp_sel));
        if (k == K_ALU || k == K_LOAD || k == K_JUMP) begin
            check({tag, "_reg_write_count"}, n_rw, 1);
            check({tag, "_reg_write_cycle"}, rw_c, len);
        end else begin
            check({tag, "_reg_write_count"}, n_rw, 0);
        end
        check({tag, "_dmem_req_cycles"}, n_dreq, is_mem ? dd + 1 : 0);
        check({tag, "_dmem_we_cycles"}, n_dwe, (k == K_STORE) ? dd + 1 : 0);
        check({tag, "_fields"}, 32'({mem_to_reg, alu_src, alu_op, u_sel, bj_type}), 32'(ef));
        check({tag, "_retired"}, retired, exp_ret);
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        logic [6:0] legal_ops[9];
        logic [6:0] bad_ops[6];
        logic [31:0] r, w;
        int n_ireq, n_dreq, n_bad, n_pc, pc_c, n_ir, ir_c;
        logic [31:0] ret0;

        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        bad_ops   = '{7'h7f, 7'h00, 7'h0b, 7'h2b, 7'h5b, 7'h7b};

        tbl.push_back('{32'h002081B3, 0, 0, 1'b0, mk(1'b0, 1'b0, 2'b00, 2'b00, 3'b010)});
        tbl.push_back('{32'h00402283, 0, 2, 1'b0, mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b010)});
        tbl.push_back('{32'h00502423, 0, 0, 1'b0, mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b010)});
        tbl.push_back('{32'h00000463, 0, 0, 1'b1, mk(1'b0, 1'b0, 2'b00, 2'b00, 3'b000)});
        tbl.push_back('{32'h00000463, 0, 0, 1'b0, mk(1'b0, 1'b0, 2'b00, 2'b00, 3'b000)});
        tbl.push_back('{32'h00209463, 1, 0, 1'b1, mk(1'b0, 1'b0, 2'b00, 2'b00, 3'b001)});
        tbl.push_back('{32'h0020C463, 2, 0, 1'b1, mk(1'b0, 1'b0, 2'b00, 2'b00, 3'b100)});
        tbl.push_back('{32'h00500093, 0, 0, 1'b0, mk(1'b0, 1'b1, 2'b01, 2'b00, 3'b010)});
        tbl.push_back('{32'h123450B7, 0, 0, 1'b0, mk(1'b0, 1'b1, 2'b10, 2'b01, 3'b010)});
        tbl.push_back('{32'h00001097, 0, 0, 1'b0, mk(1'b0, 1'b1, 2'b10, 2'b10, 3'b010)});
        tbl.push_back('{32'h010000EF, 0, 0, 1'b0, mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b011)});
        tbl.push_back('{32'h00008067, 3, 0, 1'b0, mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b011)});
        tbl.push_back('{32'h00402283, 3, 4, 1'b0, mk(1'b1, 1'b1, 2'b00, 2'b00, 3'b010)});
        tbl.push_back('{32'h00502423, 2, 5, 1'b0, mk(1'b0, 1'b1, 2'b00, 2'b00, 3'b010)});
`ifndef RV_MC_CTL_ILLEGAL_TRAP_EN
        tbl.push_back('{32'hFFFFFFFF, 0, 0, 1'b0, mk(1'b0, 1'b0, 2'b11, 2'b00, 3'b010)});
`endif

        do_reset("init");
        for (int i = 0; i < tbl.size(); i++)
            run_instr(tbl[i].w, tbl[i].di, tbl[i].dd, tbl[i].bt, tbl[i].f, $sformatf("tbl%0d", i));

        for (int n = 0; n < 40; n++) begin
            r = $urandom();
`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
            w = {r[31:7], legal_ops[$urandom_range(0, 8)]};
`else
            if ($urandom_range(0, 9) == 0)
                w = {r[31:7], bad_ops[$urandom_range(0, 5)]};
            else
                w = {r[31:7], legal_ops[$urandom_range(0, 8)]};
`endif
            run_instr(w, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                      ref_fields(w), $sformatf("rnd%0d", n));
        end

        // Ack arriving in the very cycle the fetch would expire: no fault.
        run_instr(32'h002081B3, 15, 0, 1'b0, ref_fields(32'h002081B3), "ack_at_expiry");
        run_instr(32'h00402283, 0, 15, 1'b0, ref_fields(32'h00402283), "dack_at_expiry");

        // Reset in the middle of a load's MEM wait, then a stray dmem_ack in FETCH.
        instr = 32'h00402283;
        imem_ack = 1'b1;
        next_cycle();
        imem_ack = 1'b0;
        repeat (3) next_cycle();
        do_reset("midop");
        dmem_ack = 1'b1;
        @(negedge clk);
        check("late_dack_imem_req", 32'({imem_req, ir_we, dmem_req, pc_we}), 32'b1000);
        next_cycle();
        dmem_ack = 1'b0;
        run_instr(32'h002081B3, 0, 0, 1'b0, ref_fields(32'h002081B3), "after_midop");

        // Store: stalled fetch with ack present, then a long stall in MEM.
        ret0 = retired;
        instr = 32'h00502423;
        n_bad = 0; n_dreq = 0; n_pc = 0; pc_c = 0; n_ir = 0; ir_c = 0;
        for (int c = 1; c <= 27; c++) begin
            stall    = (c <= 3) || (c >= 7 && c <= 26);
            imem_ack = (c <= 4);
            dmem_ack = (c == 27) || ((c >= 7 && c <= 26) && 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (ir_we) begin n_ir++; ir_c = c; end
            if (pc_we) begin n_pc++; pc_c = c; end
            if (stall && (ir_we || pc_we || reg_write)) n_bad++;
            if (dmem_req && dmem_we) n_dreq++;
            if (stall && retired !== ret0) n_bad++;
            if (fault) n_bad++;
            next_cycle();
        end
        stall = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_ret = exp_ret + 32'd1;
        check("stall_pulses_or_fault", n_bad, 0);
        check("stall_ir_we_cycle", ir_c, 4);
        check("stall_ir_we_count", n_ir, 1);
        check("stall_dmem_req_we_cycles", n_dreq, 21);
        check("stall_pc_we_cycle", pc_c, 27);
        check("stall_pc_we_count", n_pc, 1);
        check("stall_retired", retired, exp_ret);

        // Fetch timeout: 16 unanswered request cycles, then ERR until reset.
        do_reset("to_fetch");
        n_ireq = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (imem_req) n_ireq++;
            if (c == 16) check("to_fetch_no_early_fault", 32'(fault), 32'd0);
            next_cycle();
        end
        check("to_fetch_req_cycles", n_ireq, 16);
        check("to_fetch_fault", 32'(fault), 32'd1);
        imem_ack = 1'b1;
        n_bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (imem_req || ir_we || pc_we || reg_write || dmem_req || !fault) n_bad++;
            next_cycle();
        end
        imem_ack = 1'b0;
        check("to_fetch_err_hold", n_bad, 0);
        check("to_fetch_retired", retired, 32'd0);

        // Data timeout on a load.
        do_reset("to_mem");
        instr = 32'h00402283;
        n_dreq = 0; n_bad = 0;
        for (int c = 1; c <= 22; c++) begin
            imem_ack = (c == 1);
            @(negedge clk);
            if (dmem_req) n_dreq++;
            if (reg_write || pc_we) n_bad++;
            next_cycle();
        end
        imem_ack = 1'b0;
        check("to_mem_req_cycles", n_dreq, 16);
        check("to_mem_no_wb", n_bad, 0);
        check("to_mem_fault", 32'(fault), 32'd1);

`ifdef RV_MC_CTL_ILLEGAL_TRAP_EN
        do_reset("trap");
        instr = 32'hFFFFFFFF;
        n_pc = 0;
        for (int c = 1; c <= 6; c++) begin
            imem_ack = (c == 1);
            @(negedge clk);
            if (pc_we || reg_write) n_pc++;
            next_cycle();
        end
        imem_ack = 1'b0;
        check("trap_no_pc_we", n_pc, 0);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_fault", 32'(fault), 32'd1);
        check("trap_retired", retired, 32'd0);
        check("trap_imem_req_low", 32'(imem_req), 32'd0);
`endif

        do_reset("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
